// File: rtl/eth_config_commit_sequencer_if.sv
// Purpose: staging-write, commit, publish and ack signals of the config commit sequencer.
// Latency: none, wiring only.
// Backpressure: none; acks are pulses from the sinks, commits are coalesced requests.
interface eth_config_commit_sequencer_if #(
    parameter int MAC_SINKS = 3
);
    logic                 wr_en;
    logic [3:0]           wr_addr;
    logic [15:0]          wr_data;
    logic                 mac_commit;
    logic                 ip_commit;
    logic [47:0]          mac_address;
    logic                 mac_address_updated;
    logic [MAC_SINKS-1:0] mac_ack;
    logic [95:0]          ip_config;
    logic                 ip_config_updated;
    logic                 ip_ack;
    logic                 busy;
    logic                 timeout_err;
    logic                 err_clear;

    // Host/bench side: drives writes, commits, acks and error clear.
    modport master (
        output wr_en, wr_addr, wr_data, mac_commit, ip_commit,
        output mac_ack, ip_ack, err_clear,
        input  mac_address, mac_address_updated, ip_config, ip_config_updated,
        input  busy, timeout_err
    );

    // Sequencer side.
    modport slave (
        input  wr_en, wr_addr, wr_data, mac_commit, ip_commit,
        input  mac_ack, ip_ack, err_clear,
        output mac_address, mac_address_updated, ip_config, ip_config_updated,
        output busy, timeout_err
    );
endinterface

// File: rtl/eth_config_commit_sequencer.sv
// Purpose: stage MAC/IP config words, publish them atomically on commit, collect sink acks.
// Latency: publish pulse and new value appear one edge after the commit is seen in IDLE.
// Backpressure: commits during a transaction are held pending and coalesced; busy reflects it.
module eth_config_commit_sequencer #(
    parameter int MAC_SINKS   = 3,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    eth_config_commit_sequencer_if.slave bus
);
    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    // Counter value held during the last permitted wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MAC_WAIT = 2'd1,
        IP_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [47:0]          mac_stage_q, mac_stage_d;
    logic [95:0]          ip_stage_q, ip_stage_d;
    logic [47:0]          mac_addr_q, mac_addr_d;
    logic [95:0]          ip_cfg_q, ip_cfg_d;
    logic                 mac_upd_q, mac_upd_d;
    logic                 ip_upd_q, ip_upd_d;
    logic                 mac_pend_q, mac_pend_d;
    logic                 ip_pend_q, ip_pend_d;
    logic [MAC_SINKS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [MAC_SINKS-1:0] mask_acc;
    logic                 err_set;

    // Staging words: writable in every state, out-of-range addresses dropped.
    always_comb begin
        mac_stage_d = mac_stage_q;
        ip_stage_d  = ip_stage_q;
        if (bus.wr_en) begin
            case (bus.wr_addr)
                4'd0:    mac_stage_d[47:32] = bus.wr_data;
                4'd1:    mac_stage_d[31:16] = bus.wr_data;
                4'd2:    mac_stage_d[15:0]  = bus.wr_data;
                4'd3:    ip_stage_d[95:80]  = bus.wr_data;
                4'd4:    ip_stage_d[79:64]  = bus.wr_data;
                4'd5:    ip_stage_d[63:48]  = bus.wr_data;
                4'd6:    ip_stage_d[47:32]  = bus.wr_data;
                4'd7:    ip_stage_d[31:16]  = bus.wr_data;
                4'd8:    ip_stage_d[15:0]   = bus.wr_data;
                default: ;
            endcase
        end
    end

    // Sequencer next state: launch from IDLE (MAC has priority), then wait for acks or timeout.
    always_comb begin
        state_d    = state_q;
        mac_addr_d = mac_addr_q;
        ip_cfg_d   = ip_cfg_q;
        mac_upd_d  = 1'b0;
        ip_upd_d   = 1'b0;
        mac_pend_d = mac_pend_q | bus.mac_commit;
        ip_pend_d  = ip_pend_q | bus.ip_commit;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        err_set    = 1'b0;
        mask_acc   = mask_q | bus.mac_ack;

        case (state_q)
            IDLE: begin
                if (mac_pend_d) begin
                    // Launch uses staging as it stood before this edge.
                    mac_addr_d = mac_stage_q;
                    mac_upd_d  = 1'b1;
                    mac_pend_d = 1'b0;
                    mask_d     = '0;
                    cnt_d      = '0;
                    state_d    = MAC_WAIT;
                end else if (ip_pend_d) begin
                    ip_cfg_d  = ip_stage_q;
                    ip_upd_d  = 1'b1;
                    ip_pend_d = 1'b0;
                    mask_d    = '0;
                    cnt_d     = '0;
                    state_d   = IP_WAIT;
                end
            end
            MAC_WAIT: begin
                mask_d = mask_acc;
                // Completion is checked first so a last-cycle ack is not an error.
                if (&mask_acc) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IP_WAIT: begin
                if (bus.ip_ack) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sticky error: a new timeout outranks a simultaneous clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mac_stage_q <= '0;
            ip_stage_q  <= '0;
            mac_addr_q  <= '0;
            ip_cfg_q    <= '0;
            mac_upd_q   <= 1'b0;
            ip_upd_q    <= 1'b0;
            mac_pend_q  <= 1'b0;
            ip_pend_q   <= 1'b0;
            mask_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mac_stage_q <= mac_stage_d;
            ip_stage_q  <= ip_stage_d;
            mac_addr_q  <= mac_addr_d;
            ip_cfg_q    <= ip_cfg_d;
            mac_upd_q   <= mac_upd_d;
            ip_upd_q    <= ip_upd_d;
            mac_pend_q  <= mac_pend_d;
            ip_pend_q   <= ip_pend_d;
            mask_q      <= mask_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.mac_address         = mac_addr_q;
    assign bus.mac_address_updated = mac_upd_q;
    assign bus.ip_config           = ip_cfg_q;
    assign bus.ip_config_updated   = ip_upd_q;
    assign bus.timeout_err         = err_q;
    assign bus.busy                = (state_q != IDLE) | mac_pend_q | ip_pend_q;
endmodule

// File: tb/tb_eth_config_commit_sequencer.sv
`timescale 1ns/1ps
module tb_eth_config_commit_sequencer;
    localparam int MS = 3;
    localparam int TO = 1023;

    logic clk = 1'b0;
    logic rst_n;

    eth_config_commit_sequencer_if #(.MAC_SINKS(MS)) bus ();

    eth_config_commit_sequencer #(
        .MAC_SINKS  (MS),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #2 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction view of the sequencer.
    logic [15:0] m_stage [9];
    logic [47:0] m_mac;
    logic [95:0] m_ip;
    bit          m_mac_pulse, m_ip_pulse;
    int          m_active;      // 0 nothing outstanding, 1 MAC publish, 2 IP publish
    int          m_waited;      // wait cycles used by the outstanding publish
    bit [MS-1:0] m_seen;        // sinks that have acknowledged
    bit          m_mac_req, m_ip_req, m_err;

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_stage[i] = 16'h0;
        m_mac = '0; m_ip = '0; m_mac_pulse = 0; m_ip_pulse = 0;
        m_active = 0; m_waited = 0; m_seen = '0;
        m_mac_req = 0; m_ip_req = 0; m_err = 0;
    endtask

    task automatic model_eval();
        bit timed_out;
        timed_out   = 0;
        m_mac_pulse = 0;
        m_ip_pulse  = 0;
        m_mac_req   = m_mac_req || bus.mac_commit;
        m_ip_req    = m_ip_req || bus.ip_commit;
        if (m_active == 0) begin
            if (m_mac_req) begin
                m_mac = {m_stage[0], m_stage[1], m_stage[2]};
                m_mac_pulse = 1; m_mac_req = 0; m_active = 1; m_seen = '0; m_waited = 0;
            end else if (m_ip_req) begin
                m_ip = {m_stage[3], m_stage[4], m_stage[5], m_stage[6], m_stage[7], m_stage[8]};
                m_ip_pulse = 1; m_ip_req = 0; m_active = 2; m_waited = 0;
            end
        end else begin
            bit done;
            m_waited++;
            if (m_active == 1) begin
                m_seen = m_seen | bus.mac_ack;
                done = (m_seen == {MS{1'b1}});
            end else begin
                done = bus.ip_ack;
            end
            if (done) m_active = 0;
            else if (m_waited >= TO) begin m_active = 0; timed_out = 1; end
        end
        if (timed_out) m_err = 1;
        else if (bus.err_clear) m_err = 0;
        if (bus.wr_en && bus.wr_addr <= 4'd8) m_stage[bus.wr_addr] = bus.wr_data;
    endtask

    task automatic drive_idle();
        bus.wr_en = 0; bus.wr_addr = 4'h0; bus.wr_data = 16'h0;
        bus.mac_commit = 0; bus.ip_commit = 0;
        bus.mac_ack = '0; bus.ip_ack = 0; bus.err_clear = 0;
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [15:0] d);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1;
        #3 rst_n = 0;
        #1;
        model_reset();
        n_tests++;
        if ({bus.mac_address, bus.mac_address_updated, bus.ip_config, bus.ip_config_updated,
             bus.busy, bus.timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got mac=%h ip=%h busy=%b err=%b, expected all zero",
                     bus.mac_address, bus.ip_config, bus.busy, bus.timeout_err);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        step();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.mac_address_updated !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b upd=%b, expected 0 0", bus.busy, bus.mac_address_updated);
        end
    endtask

    task automatic test_mac_basic();
        write_word(4'd0, 16'h0200);
        write_word(4'd1, 16'h0000);
        write_word(4'd2, 16'h0001);
        write_word(4'd9, 16'h1234);
        n_tests++;
        if (bus.mac_address !== 48'h0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL staging_isolated: got mac=%h busy=%b, expected 0 0", bus.mac_address, bus.busy);
        end
        bus.mac_commit = 1;
        step();
        bus.mac_commit = 0;
        n_tests++;
        if (bus.mac_address !== 48'h020000000001 || bus.mac_address_updated !== 1'b1) begin
            n_fail++;
            $display("FAIL mac_launch: got mac=%h upd=%b, expected 020000000001 1",
                     bus.mac_address, bus.mac_address_updated);
        end
        bus.mac_ack = 3'b101;
        step();
        n_tests++;
        if (bus.mac_address_updated !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mac_pulse_width: got upd=%b busy=%b, expected 0 1",
                     bus.mac_address_updated, bus.busy);
        end
        bus.mac_ack = 3'b010;
        step();
        bus.mac_ack = '0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mac_complete: got busy=%b err=%b, expected 0 0", bus.busy, bus.timeout_err);
        end
    endtask

    task automatic test_both_commit();
        logic [15:0] w [6];
        w = '{16'hC0A8, 16'h0001, 16'hFFFF, 16'hFF00, 16'hC0A8, 16'h00FE};
        for (int i = 0; i < 6; i++) write_word(4'(i + 3), w[i]);
        bus.mac_commit = 1; bus.ip_commit = 1;
        step();
        bus.mac_commit = 0; bus.ip_commit = 0;
        n_tests++;
        if (bus.mac_address_updated !== 1'b1 || bus.ip_config_updated !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL both_mac_first: got mupd=%b iupd=%b busy=%b, expected 1 0 1",
                     bus.mac_address_updated, bus.ip_config_updated, bus.busy);
        end
        for (int i = 0; i < MS; i++) begin
            bus.mac_ack = '0;
            bus.mac_ack[i] = 1'b1;
            step();
        end
        bus.mac_ack = '0;
        n_tests++;
        if (bus.ip_config_updated !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL both_ip_pending: got iupd=%b busy=%b, expected 0 1", bus.ip_config_updated, bus.busy);
        end
        step();
        n_tests++;
        if (bus.ip_config_updated !== 1'b1 || bus.ip_config !== 96'hC0A80001FFFFFF00C0A800FE) begin
            n_fail++;
            $display("FAIL both_ip_launch: got iupd=%b ip=%h, expected 1 c0a80001ffffff00c0a800fe",
                     bus.ip_config_updated, bus.ip_config);
        end
        bus.ip_ack = 1;
        step();
        bus.ip_ack = 0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0 || bus.ip_config_updated !== 1'b0) begin
            n_fail++;
            $display("FAIL both_ip_done: got busy=%b err=%b iupd=%b, expected 0 0 0",
                     bus.busy, bus.timeout_err, bus.ip_config_updated);
        end
    endtask

    task automatic test_coalesce();
        int pulses;
        bus.mac_commit = 1;
        step();
        bus.mac_commit = 0;
        write_word(4'd2, 16'hBEEF);
        bus.mac_commit = 1; step();
        bus.mac_commit = 0; step();
        bus.mac_commit = 1; step();
        bus.mac_commit = 0;
        n_tests++;
        if (bus.mac_address !== 48'h020000000001 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL coalesce_hold: got mac=%h busy=%b, expected 020000000001 1", bus.mac_address, bus.busy);
        end
        pulses = 0;
        bus.mac_ack = 3'b111;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.mac_address_updated === 1'b1) pulses++;
        end
        bus.mac_ack = '0;
        n_tests++;
        if (pulses !== 1 || bus.mac_address !== 48'h02000000BEEF || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL coalesce_relaunch: got pulses=%0d mac=%h busy=%b, expected 1 02000000beef 0",
                     pulses, bus.mac_address, bus.busy);
        end
    endtask

    task automatic test_timeout();
        // Run 0: plain timeout then clear; 1: clear on timeout cycle; 2: completion on last cycle.
        for (int run = 0; run < 3; run++) begin
            bus.mac_commit = 1;
            step();
            bus.mac_commit = 0;
            bus.mac_ack = 3'b011;
            for (int i = 0; i < TO - 1; i++) step();
            n_tests++;
            if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_early_r%0d: got err=%b busy=%b, expected 0 1", run, bus.timeout_err, bus.busy);
            end
            if (run == 1) bus.err_clear = 1;
            if (run == 2) bus.mac_ack = 3'b111;
            step();
            bus.err_clear = 0;
            bus.mac_ack = '0;
            n_tests++;
            if (bus.timeout_err !== (run != 2) || bus.busy !== 1'b0 || bus.mac_address !== m_mac) begin
                n_fail++;
                $display("FAIL timeout_end_r%0d: got err=%b busy=%b mac=%h, expected %b 0 %h",
                         run, bus.timeout_err, bus.busy, bus.mac_address, (run != 2), m_mac);
            end
            bus.err_clear = 1;
            step();
            bus.err_clear = 0;
            n_tests++;
            if (bus.timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_clear_r%0d: got err=%b, expected 0", run, bus.timeout_err);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        write_word(4'd3, 16'h0A0B);
        bus.ip_commit = 1;
        step();
        bus.ip_commit = 0;
        step();
        n_tests++;
        if (bus.busy !== 1'b1 || bus.ip_config[95:80] !== 16'h0A0B) begin
            n_fail++;
            $display("FAIL rst_pre_wait: got busy=%b ipw0=%h, expected 1 0a0b", bus.busy, bus.ip_config[95:80]);
        end
        #1 rst_n = 0;
        #0.5;
        model_reset();
        n_tests++;
        if ({bus.mac_address, bus.mac_address_updated, bus.ip_config, bus.ip_config_updated,
             bus.busy, bus.timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got mac=%h ip=%h busy=%b, expected all zero",
                     bus.mac_address, bus.ip_config, bus.busy);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        bus.ip_ack = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (bus.ip_config_updated !== 1'b0 || bus.busy !== 1'b0 || bus.ip_config !== 96'h0) begin
                n_fail++;
                $display("FAIL rst_after_%0d: got iupd=%b busy=%b ip=%h, expected 0 0 0",
                         i, bus.ip_config_updated, bus.busy, bus.ip_config);
            end
        end
        bus.ip_ack = 0;
    endtask

    task automatic test_random();
        logic [150:0] got, exp;
        for (int c = 0; c < 4000; c++) begin
            bus.wr_en      = ($urandom_range(0, 9) < 3);
            bus.wr_addr    = 4'($urandom_range(0, 15));
            bus.wr_data    = 16'($urandom);
            bus.mac_commit = ($urandom_range(0, 19) == 0);
            bus.ip_commit  = ($urandom_range(0, 19) == 0);
            for (int b = 0; b < MS; b++) bus.mac_ack[b] = ($urandom_range(0, 4) == 0);
            bus.ip_ack     = ($urandom_range(0, 6) == 0);
            bus.err_clear  = ($urandom_range(0, 29) == 0);
            step();
            got = {bus.mac_address, bus.mac_address_updated, bus.ip_config, bus.ip_config_updated,
                   bus.busy, bus.timeout_err};
            exp = {m_mac, m_mac_pulse, m_ip, m_ip_pulse,
                   (m_active != 0) || m_mac_req || m_ip_req, m_err};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_c%0d: got %h expected %h", c, got, exp);
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_mac_basic();
        test_both_commit();
        test_coalesce();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
